conv_tile_sched: RTL and testbench

Tile-level scheduler between the kernel control block and the conv engine. It receives one op_start pulse per kernel invocation and walks the output space in x, y and output-channel-group tiles. For each tile it issues a one-cycle tile_start with the tile coordinates and waits for tile_done. It holds off issuing while the write buffer is back-pressured, and returns a single end_conv pulse when the last tile completes.

---
 rtl/conv_tile_sched_pkg.sv | 14 +
 rtl/conv_tile_sched_if.sv | 43 ++++
 rtl/conv_tile_sched_tile_coord_cnt.sv | 64 ++++++
 rtl/conv_tile_sched.sv | 129 ++++++++++++
 tb/tb_conv_tile_sched.sv | 316 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/conv_tile_sched_pkg.sv
// Shared definitions for the conv tile scheduler.
// Holds the scheduler state encoding (also exported on the debug state
// output) and the default width of tile counts and coordinates.
package conv_tile_sched_pkg;

    localparam int CNT_W_DEFAULT = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

endpackage

// File: rtl/conv_tile_sched_if.sv
// Signal bundle between kernel control / conv engine and the tile scheduler.
//   master : kernel control + engine side (drives op_start, cfg_*, wbuf_full,
//            tile_done; observes tile_start, tile_x/y/oc, busy, end_conv,
//            cfg_err, dbg_state)
//   slave  : the scheduler
//
// Handshake semantics: every event is a one-cycle pulse sampled on the rising
// clock edge. op_start is accepted only while busy=0. tile_start issues a tile
// only when wbuf_full was 0 at the issuing edge; the tile is complete at the
// first edge after that tile_start where tile_done=1 (tile_done during the
// tile_start cycle itself counts). tile_done outside a pending tile is dropped.
interface conv_tile_sched_if
    import conv_tile_sched_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) ();

    logic             op_start;
    logic [CNT_W-1:0] cfg_tiles_x;
    logic [CNT_W-1:0] cfg_tiles_y;
    logic [CNT_W-1:0] cfg_oc_groups;
    logic             wbuf_full;
    logic             tile_done;
    logic             tile_start;
    logic [CNT_W-1:0] tile_x;
    logic [CNT_W-1:0] tile_y;
    logic [CNT_W-1:0] tile_oc;
    logic             busy;
    logic             end_conv;
    logic             cfg_err;
    state_t           dbg_state;

    modport master (
        output op_start, cfg_tiles_x, cfg_tiles_y, cfg_oc_groups, wbuf_full, tile_done,
        input  tile_start, tile_x, tile_y, tile_oc, busy, end_conv, cfg_err, dbg_state
    );

    modport slave (
        input  op_start, cfg_tiles_x, cfg_tiles_y, cfg_oc_groups, wbuf_full, tile_done,
        output tile_start, tile_x, tile_y, tile_oc, busy, end_conv, cfg_err, dbg_state
    );

endinterface

// File: rtl/conv_tile_sched_tile_coord_cnt.sv
// tile_coord_cnt: three-level nested wrap counter over (x, y, oc).
// x is innermost, oc outermost. Coordinates are registers so they are directly
// usable as registered scheduler outputs.
//   clear            : force all coordinates to 0 (start of a job)
//   advance          : step to the next tile in x, y, oc order
//   cnt_x/cnt_y/cnt_oc : latched tile counts (non-zero while advancing)
//   x, y, oc         : current tile coordinates
//   is_last          : combinational, current tile is the final one of the job
module tile_coord_cnt
    import conv_tile_sched_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             advance,
    input  logic [CNT_W-1:0] cnt_x,
    input  logic [CNT_W-1:0] cnt_y,
    input  logic [CNT_W-1:0] cnt_oc,
    output logic [CNT_W-1:0] x,
    output logic [CNT_W-1:0] y,
    output logic [CNT_W-1:0] oc,
    output logic             is_last
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic x_wrap;
    logic y_wrap;
    logic oc_wrap;

    // Comparing against count-1 keeps everything CNT_W wide, so a count of
    // 2^CNT_W-1 never needs the coordinate to reach 2^CNT_W.
    assign x_wrap  = (x == cnt_x - ONE);
    assign y_wrap  = (y == cnt_y - ONE);
    assign oc_wrap = (oc == cnt_oc - ONE);
    assign is_last = x_wrap && y_wrap && oc_wrap;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x  <= '0;
            y  <= '0;
            oc <= '0;
        end else if (clear) begin
            x  <= '0;
            y  <= '0;
            oc <= '0;
        end else if (advance) begin
            if (x_wrap) begin
                x <= '0;
                if (y_wrap) begin
                    y  <= '0;
                    oc <= oc + ONE;
                end else begin
                    y <= y + ONE;
                end
            end else begin
                x <= x + ONE;
            end
        end
    end

endmodule

// File: rtl/conv_tile_sched.sv
// conv_tile_sched: walks the output space of one kernel invocation in tiles.
// One op_start starts a job; each tile is issued with a tile_start pulse and
// coordinates, then the scheduler waits for tile_done. Issue is held off while
// wbuf_full is high. A single end_conv pulse marks the end of the job; a zero
// tile count ends the job immediately and raises the sticky cfg_err.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of conv_tile_sched_if (all outputs registered,
//                dbg_state exposes the FSM state)
module conv_tile_sched
    import conv_tile_sched_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    conv_tile_sched_if.slave bus
);

    state_t           state_q, state_d;
    logic             tile_start_q, tile_start_d;
    logic             end_conv_q, end_conv_d;
    logic             busy_q, busy_d;
    logic             cfg_err_q, cfg_err_d;
    logic [CNT_W-1:0] tx_q, ty_q, toc_q;
    logic             latch_cfg;
    logic             cnt_clear;
    logic             cnt_advance;
    logic             cfg_zero;
    logic             is_last;
    logic [CNT_W-1:0] coord_x, coord_y, coord_oc;

    assign cfg_zero = (bus.cfg_tiles_x == '0) || (bus.cfg_tiles_y == '0) ||
                      (bus.cfg_oc_groups == '0);

    tile_coord_cnt #(.CNT_W(CNT_W)) u_coord (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (cnt_clear),
        .advance (cnt_advance),
        .cnt_x   (tx_q),
        .cnt_y   (ty_q),
        .cnt_oc  (toc_q),
        .x       (coord_x),
        .y       (coord_y),
        .oc      (coord_oc),
        .is_last (is_last)
    );

    always_comb begin
        state_d      = state_q;
        tile_start_d = 1'b0;
        end_conv_d   = 1'b0;
        busy_d       = busy_q;
        cfg_err_d    = cfg_err_q;
        latch_cfg    = 1'b0;
        cnt_clear    = 1'b0;
        cnt_advance  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.op_start) begin
                    latch_cfg = 1'b1;
                    cnt_clear = 1'b1;
                    if (cfg_zero) begin
                        // Degenerate job: report and finish without issuing.
                        cfg_err_d  = 1'b1;
                        end_conv_d = 1'b1;
                    end else begin
                        cfg_err_d = 1'b0;
                        busy_d    = 1'b1;
                        state_d   = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                if (!bus.wbuf_full) begin
                    tile_start_d = 1'b1;
                    state_d      = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (bus.tile_done) begin
                    if (is_last) begin
                        end_conv_d = 1'b1;
                        busy_d     = 1'b0;
                        state_d    = ST_IDLE;
                    end else begin
                        cnt_advance = 1'b1;
                        state_d     = ST_ISSUE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            tile_start_q <= 1'b0;
            end_conv_q   <= 1'b0;
            busy_q       <= 1'b0;
            cfg_err_q    <= 1'b0;
            tx_q         <= '0;
            ty_q         <= '0;
            toc_q        <= '0;
        end else begin
            state_q      <= state_d;
            tile_start_q <= tile_start_d;
            end_conv_q   <= end_conv_d;
            busy_q       <= busy_d;
            cfg_err_q    <= cfg_err_d;
            if (latch_cfg) begin
                tx_q  <= bus.cfg_tiles_x;
                ty_q  <= bus.cfg_tiles_y;
                toc_q <= bus.cfg_oc_groups;
            end
        end
    end

    assign bus.tile_start = tile_start_q;
    assign bus.tile_x     = coord_x;
    assign bus.tile_y     = coord_y;
    assign bus.tile_oc    = coord_oc;
    assign bus.busy       = busy_q;
    assign bus.end_conv   = end_conv_q;
    assign bus.cfg_err    = cfg_err_q;
    assign bus.dbg_state  = state_q;

endmodule

// File: tb/tb_conv_tile_sched.sv
// Self-checking bench for conv_tile_sched. The reference model expands each
// job into its expected event list (tiles in x/y/oc order, then one end
// event carrying the expected cfg_err) and a monitor pops/compares every
// tile_start and end_conv the DUT presents.
module tb_conv_tile_sched;
    import conv_tile_sched_pkg::*;

    localparam int CW = 8;
    localparam int EW = 1 + 3 * CW;

    logic clk;
    logic rst_n;
    int   cyc = 0;

    conv_tile_sched_if #(.CNT_W(CW)) bus ();

    conv_tile_sched #(.CNT_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    logic [EW-1:0] exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;
    int tile_cnt = 0;
    int end_cnt  = 0;
    int first_tile_cyc = -1;
    int last_end_cyc   = -1;
    int last_done_cyc  = -1;
    int start_cyc      = 0;
    bit wb_prev = 1'b0;

    // responder / wbuf control
    int resp_min = 0;
    int resp_max = 0;
    int pend = 0;
    bit spur_en = 1'b0;
    bit wbuf_rand = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [EW-1:0] tile_ent(input int x, input int y, input int oc);
        return {1'b0, CW'(x), CW'(y), CW'(oc)};
    endfunction

    function automatic logic [EW-1:0] end_ent(input bit err);
        return {1'b1, {(3 * CW - 1){1'b0}}, err};
    endfunction

    // Reference model: a job is its tiles in nested order followed by the end.
    task automatic model_job(input int tx, input int ty, input int toc);
        if (tx == 0 || ty == 0 || toc == 0) begin
            exp_q.push_back(end_ent(1'b1));
        end else begin
            for (int oc = 0; oc < toc; oc++)
                for (int y = 0; y < ty; y++)
                    for (int x = 0; x < tx; x++)
                        exp_q.push_back(tile_ent(x, y, oc));
            exp_q.push_back(end_ent(1'b0));
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.tile_start) begin
                tile_cnt++;
                if (first_tile_cyc < 0) first_tile_cyc = cyc;
                check("tile_start_after_wbuf_free", {31'b0, wb_prev}, 32'd0);
                check("busy_during_tile", {31'b0, bus.busy}, 32'd1);
                check("sb_nonempty_on_tile", {31'b0, exp_q.size() != 0}, 32'd1);
                if (exp_q.size() != 0)
                    check("tile_coord", 32'({1'b0, bus.tile_x, bus.tile_y, bus.tile_oc}),
                          32'(exp_q.pop_front()));
            end
            if (bus.end_conv) begin
                end_cnt++;
                last_end_cyc = cyc;
                check("busy_low_at_end", {31'b0, bus.busy}, 32'd0);
                check("sb_nonempty_on_end", {31'b0, exp_q.size() != 0}, 32'd1);
                if (exp_q.size() != 0)
                    check("end_event", 32'(end_ent(bus.cfg_err)), 32'(exp_q.pop_front()));
            end
        end
        wb_prev = bus.wbuf_full;
    end

    // ---------------- engine responder ----------------
    always @(negedge clk) begin
        if (!rst_n) begin
            pend = 0;
            bus.tile_done = 1'b0;
        end else begin
            bus.tile_done = 1'b0;
            if (bus.tile_start) begin
                pend = $urandom_range(resp_max, resp_min);
                if (pend == 0) begin
                    bus.tile_done = 1'b1;
                    last_done_cyc = cyc;
                end
            end else if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    bus.tile_done = 1'b1;
                    last_done_cyc = cyc;
                end
            end else if (spur_en && bus.dbg_state == ST_ISSUE && $urandom_range(0, 1) == 1) begin
                bus.tile_done = 1'b1;
            end
        end
    end

    // ---------------- write-buffer back-pressure ----------------
    always @(posedge clk) begin
        if (wbuf_rand) begin
            #1;
            bus.wbuf_full = ($urandom_range(0, 3) == 0);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic start_job(input int tx, input int ty, input int toc);
        @(posedge clk); #1;
        bus.op_start      = 1'b1;
        bus.cfg_tiles_x   = CW'(tx);
        bus.cfg_tiles_y   = CW'(ty);
        bus.cfg_oc_groups = CW'(toc);
        start_cyc = cyc;
        model_job(tx, ty, toc);
        @(posedge clk); #1;
        bus.op_start      = 1'b0;
        bus.cfg_tiles_x   = CW'($urandom);
        bus.cfg_tiles_y   = CW'($urandom);
        bus.cfg_oc_groups = CW'($urandom);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        check("job_done_in_budget", exp_q.size(), 32'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
    endtask

    // Pulse op_start with junk config while the DUT sits in WAIT.
    task automatic stray_op_start_in_wait();
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            if (bus.dbg_state == ST_WAIT) begin
                bus.op_start      = 1'b1;
                bus.cfg_tiles_x   = CW'($urandom);
                bus.cfg_tiles_y   = CW'($urandom);
                bus.cfg_oc_groups = CW'($urandom);
                @(posedge clk); #1;
                bus.op_start = 1'b0;
                break;
            end
            if (exp_q.size() == 0) break;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tile_start"}, {31'b0, bus.tile_start}, 32'd0);
        check({tag, "_tile_xyz"}, 32'({bus.tile_x, bus.tile_y, bus.tile_oc}), 32'd0);
        check({tag, "_busy"}, {31'b0, bus.busy}, 32'd0);
        check({tag, "_end_conv"}, {31'b0, bus.end_conv}, 32'd0);
        check({tag, "_cfg_err"}, {31'b0, bus.cfg_err}, 32'd0);
        check({tag, "_state"}, 32'(bus.dbg_state), 32'(ST_IDLE));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int t0, e0, fall_cyc, tx, ty, toc;
        rst_n = 1'b0;
        bus.op_start = 1'b0;
        bus.cfg_tiles_x = '0;
        bus.cfg_tiles_y = '0;
        bus.cfg_oc_groups = '0;
        bus.wbuf_full = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // T1: 2x2x1, done 3 cycles after each tile_start
        resp_min = 3; resp_max = 3;
        t0 = tile_cnt; e0 = end_cnt; first_tile_cyc = -1;
        start_job(2, 2, 1);
        wait_idle(200);
        check("t1_tiles", tile_cnt - t0, 32'd4);
        check("t1_ends", end_cnt - e0, 32'd1);
        check("t1_first_latency", first_tile_cyc - start_cyc, 32'd2);
        check("t1_end_after_done", last_end_cyc - last_done_cyc, 32'd1);

        // T2: 1x1x3 with 10-cycle write-buffer stall
        resp_min = 0; resp_max = 3;
        bus.wbuf_full = 1'b1;
        t0 = tile_cnt; e0 = end_cnt; first_tile_cyc = -1;
        start_job(1, 1, 3);
        repeat (9) @(posedge clk);
        check("t2_no_tile_in_stall", tile_cnt - t0, 32'd0);
        #1;
        bus.wbuf_full = 1'b0;
        fall_cyc = cyc;
        wait_idle(200);
        check("t2_first_after_release", first_tile_cyc - fall_cyc, 32'd1);
        check("t2_tiles", tile_cnt - t0, 32'd3);
        check("t2_ends", end_cnt - e0, 32'd1);

        // T3: zero count, then a valid 1x1x1
        t0 = tile_cnt; e0 = end_cnt;
        start_job(3, 0, 2);
        wait_idle(20);
        check("t3_zero_end_latency", last_end_cyc - start_cyc, 32'd1);
        check("t3_cfg_err_sticky", {31'b0, bus.cfg_err}, 32'd1);
        check("t3_no_tiles", tile_cnt - t0, 32'd0);
        start_job(1, 1, 1);
        wait_idle(50);
        check("t3_cfg_err_cleared", {31'b0, bus.cfg_err}, 32'd0);
        check("t3_tiles_after_valid", tile_cnt - t0, 32'd1);
        check("t3_ends", end_cnt - e0, 32'd2);

        // T4: stray op_start in WAIT and spurious tile_done in ISSUE
        resp_min = 2; resp_max = 4;
        spur_en = 1'b1; wbuf_rand = 1'b1;
        t0 = tile_cnt; e0 = end_cnt;
        start_job(2, 2, 2);
        stray_op_start_in_wait();
        stray_op_start_in_wait();
        wait_idle(400);
        check("t4_tiles", tile_cnt - t0, 32'd8);
        check("t4_ends", end_cnt - e0, 32'd1);
        spur_en = 1'b0; wbuf_rand = 1'b0;
        @(posedge clk); #1;
        bus.wbuf_full = 1'b0;

        // T5: reset during the 2nd tile of a 3x1x1 job
        resp_min = 3; resp_max = 3;
        e0 = end_cnt; t0 = tile_cnt;
        start_job(3, 1, 1);
        for (int i = 0; i < 50 && tile_cnt - t0 < 2; i++) @(posedge clk);
        check("t5_reached_tile2", tile_cnt - t0, 32'd2);
        @(posedge clk); #1;
        rst_n = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check_reset_outputs("midrst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        check("t5_no_end_after_reset", end_cnt - e0, 32'd0);
        t0 = tile_cnt;
        start_job(3, 1, 1);
        wait_idle(100);
        check("t5_restart_tiles", tile_cnt - t0, 32'd3);
        check("t5_restart_ends", end_cnt - e0, 32'd1);

        // T6: 255x1x1 full-range x
        resp_min = 0; resp_max = 1;
        t0 = tile_cnt; e0 = end_cnt;
        start_job(255, 1, 1);
        wait_idle(1500);
        check("t6_tiles", tile_cnt - t0, 32'd255);
        check("t6_ends", end_cnt - e0, 32'd1);

        // Random jobs with back-pressure, stray inputs and occasional zero counts
        resp_min = 0; resp_max = 3;
        spur_en = 1'b1; wbuf_rand = 1'b1;
        for (int j = 0; j < 20; j++) begin
            tx  = $urandom_range(1, 4);
            ty  = $urandom_range(1, 4);
            toc = $urandom_range(1, 3);
            if ($urandom_range(0, 5) == 0) begin
                case ($urandom_range(0, 2))
                    0: tx = 0;
                    1: ty = 0;
                    default: toc = 0;
                endcase
            end
            e0 = end_cnt;
            start_job(tx, ty, toc);
            if (tx != 0 && ty != 0 && toc != 0 && $urandom_range(0, 1) == 1)
                stray_op_start_in_wait();
            wait_idle(2000);
            check("rand_one_end", end_cnt - e0, 32'd1);
            check("rand_cfg_err", {31'b0, bus.cfg_err},
                  {31'b0, (tx == 0 || ty == 0 || toc == 0)});
        end
        wbuf_rand = 1'b0;
        spur_en = 1'b0;

        repeat (5) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
